imm_gen_pipe: RTL and testbench

//  Registered, flow-controlled immediate generator for the ID stage. Accepts {ImmSel, inst, tag}
//  and emits the XLEN-wide immediate one cycle later through a valid/ready stage with a 2-entry skid.

---
 rtl/imm_gen_pipe_pkg.sv | 29 ++
 rtl/imm_gen_pipe_comb.sv | 42 ++++
 rtl/imm_gen_pipe.sv | 136 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the immediate-generator pipeline: ImmSel codes, occupancy states,
// and the XLEN legality check used at elaboration.
package imm_gen_pipe_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        IMM_TYPE_NONE  = 3'b000,
        IMM_TYPE_I     = 3'b001,
        IMM_TYPE_B     = 3'b010,
        IMM_TYPE_J     = 3'b011,
        IMM_TYPE_S     = 3'b100,
        IMM_TYPE_U     = 3'b101,
        IMM_TYPE_Z     = 3'b110,
        IMM_TYPE_SHAMT = 3'b111
    } imm_type_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_comb.sv
// Pure combinational immediate decode: (ImmSel, inst) -> XLEN immediate plus illegal-encoding flag.
// The flag is only computed when IMM_ERR_EN is defined; otherwise it is tied 0.
module imm_gen_comb
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [SEL_W-1:0]  imm_sel_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [XLEN-1:0]   imm_o,
    output logic              err_o
);

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst_i[6:0];

    always_comb begin
        imm_o = '0;
        case (imm_type_e'(imm_sel_i))
            IMM_TYPE_I:     imm_o = XLEN'($signed(inst_i[31:20]));
            IMM_TYPE_B:     imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                                   inst_i[11:8], 1'b0}));
            IMM_TYPE_J:     imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                                   inst_i[30:21], 1'b0}));
            IMM_TYPE_S:     imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
            IMM_TYPE_U:     imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
            IMM_TYPE_Z:     imm_o = XLEN'(inst_i[19:15]);
            IMM_TYPE_SHAMT: imm_o = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
            default:        imm_o = '0;
        endcase
    end

`ifdef IMM_ERR_EN
    // NONE is never legal; a 6-bit shift amount is illegal on RV32.
    assign err_o = (imm_type_e'(imm_sel_i) == IMM_TYPE_NONE) ||
                   ((imm_type_e'(imm_sel_i) == IMM_TYPE_SHAMT) && (XLEN == 32) && inst_i[25]);
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, flow-controlled immediate generator with a 2-entry (output + skid) buffer.
// Optional IMM_ERR_EN macro stores an illegal-encoding flag with each entry.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  ImmSel,
    input  logic [INST_W-1:0] inst,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

`ifdef IMM_ERR_EN
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;
`else
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
    } entry_t;
`endif

    occ_e        state_q, state_d;
    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    entry_t      new_entry;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        accept;
    logic        pop;
    logic [XLEN-1:0] new_imm;
    logic        new_err;

    imm_gen_comb #(
        .XLEN (XLEN)
    ) u_comb (
        .imm_sel_i (ImmSel),
        .inst_i    (inst),
        .imm_o     (new_imm),
        .err_o     (new_err)
    );

`ifdef IMM_ERR_EN
    assign new_entry = '{imm: new_imm, tag: in_tag, err: new_err};
`else
    logic unused_err;
    assign unused_err = new_err;
    assign new_entry  = '{imm: new_imm, tag: in_tag};
`endif

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid_q && out_ready;

    // Occupancy next-state and buffer steering; flush overrides accept and pop.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        out_d   = new_entry;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        out_d = new_entry;
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = OCC_TWO;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        out_d   = skid_q;
                        state_d = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        out_valid_d = (state_d != OCC_EMPTY);
        in_ready_d  = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_q.imm;
    assign out_tag   = out_q.tag;
`ifdef IMM_ERR_EN
    assign out_err   = out_q.err;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: RV32 and RV64 instances share stimulus and handshake;
// an arithmetic reference model predicts each immediate and the buffer occupancy.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  imm_sel = 3'd0;
    logic [31:0] inst = 32'd0;
    logic [31:0] in_tag = 32'd0;
    logic        out_ready = 1'b1;

    logic        rdy32, ov32, err32;
    logic [31:0] imm32, tag32;
    logic        rdy64, ov64, err64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .ImmSel(imm_sel), .inst(inst), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_tag(tag32), .out_err(err32));

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .ImmSel(imm_sel), .inst(inst), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_tag(tag64), .out_err(err64));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   total = 0;
    int   passed = 0;
    bit   mdl_on = 1'b0;
    bit   mdl_rdy = 1'b0;
    bit   chk_rst = 1'b0;
    bit   rdy_mode = 1'b0;

    // Immediate as a weighted sum of instruction fields, sign bit carrying negative weight.
    function automatic logic [63:0] ref_imm(input logic [2:0] sel, input logic [31:0] w, input int xl);
        longint v;
        longint s;
        s = w[31] ? 64'sd1 : 64'sd0;
        case (sel)
            3'd1: v = longint'(w[31:20]) - s * 64'sd4096;
            3'd2: v = longint'(w[7]) * 64'sd2048 + longint'(w[30:25]) * 64'sd32
                      + longint'(w[11:8]) * 64'sd2 - s * 64'sd4096;
            3'd3: v = longint'(w[19:12]) * 64'sd4096 + longint'(w[20]) * 64'sd2048
                      + longint'(w[30:21]) * 64'sd2 - s * 64'sd1048576;
            3'd4: v = longint'(w[31:25]) * 64'sd32 + longint'(w[11:7]) - s * 64'sd4096;
            3'd5: v = longint'(w[31:12]) * 64'sd4096 - s * 64'sd4294967296;
            3'd6: v = longint'(w[19:15]);
            3'd7: v = (xl == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: v = 64'sd0;
        endcase
        if (xl == 32) v = v & 64'sh0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic logic ref_err(input logic [2:0] sel, input logic [31:0] w, input int xl);
`ifdef IMM_ERR_EN
        return (sel == 3'd0) || (sel == 3'd7 && xl == 32 && w[25]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Monitor and occupancy model, evaluated mid-cycle when all signals are stable.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mdl_on) begin
            chk("in_ready32", 64'(rdy32), 64'(mdl_rdy));
            chk("in_ready64", 64'(rdy64), 64'(mdl_rdy));
            chk("out_valid32", 64'(ov32), 64'(q32.size() > 0));
            chk("out_valid64", 64'(ov64), 64'(q64.size() > 0));
            if (chk_rst) begin
                chk("rst_imm32", 64'(imm32), 64'd0);
                chk("rst_imm64", imm64, 64'd0);
                chk("rst_tag32", 64'(tag32), 64'd0);
                chk("rst_err32", 64'(err32), 64'd0);
                chk_rst = 1'b0;
            end
        end
        if (!rst_n) begin
            q32.delete();
            q64.delete();
            mdl_rdy = 1'b0;
            mdl_on  = 1'b1;
            chk_rst = 1'b1;
        end else if (mdl_on) begin
            if (flush) begin
                q32.delete();
                q64.delete();
                mdl_rdy = 1'b1;
            end else begin
                if (out_ready && q32.size() > 0) begin
                    e = q32.pop_front();
                    chk("imm32", 64'(imm32), e.imm);
                    chk("tag32", 64'(tag32), 64'(e.tag));
                    chk("err32", 64'(err32), 64'(e.err));
                    e = q64.pop_front();
                    chk("imm64", imm64, e.imm);
                    chk("tag64", 64'(tag64), 64'(e.tag));
                    chk("err64", 64'(err64), 64'(e.err));
                end
                if (in_valid && mdl_rdy) begin
                    q32.push_back('{imm: ref_imm(imm_sel, inst, 32), tag: in_tag,
                                    err: ref_err(imm_sel, inst, 32)});
                    q64.push_back('{imm: ref_imm(imm_sel, inst, 64), tag: in_tag,
                                    err: ref_err(imm_sel, inst, 64)});
                end
                mdl_rdy = (q32.size() < 2);
            end
        end
    end

    // Random backpressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode) out_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic send(input logic [2:0] sel, input logic [31:0] w, input logic [31:0] tag);
        bit acc;
        imm_sel  = sel;
        inst     = w;
        in_tag   = tag;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = rdy32 && rst_n && !flush;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        in_valid = 1'b1;
        imm_sel  = 3'd1;
        inst     = 32'h7FF0_0093;
        in_tag   = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Directed encodings, free-flowing output
        send(3'd1, 32'hFFF0_0093, 32'h0000_1000);
        send(3'd2, 32'hFE00_0EE3, 32'h0000_1004);
        send(3'd5, 32'h1234_5037, 32'h0000_1008);
        send(3'd6, 32'h000F_8073, 32'h0000_100C);
        send(3'd7, 32'h03F0_0013, 32'h0000_1010);
        send(3'd1, 32'h8000_0013, 32'h0000_1014);
        send(3'd3, 32'h8000_006F, 32'h0000_1018);
        send(3'd4, 32'hFE11_2E23, 32'h0000_101C);
        idle(3);

        // Six back-to-back entries against three stalled cycles
        out_ready = 1'b0;
        fork
            for (int t = 1; t <= 6; t++) send(3'd1, $urandom, 32'(t));
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);

        // Flush while full, with a concurrent input that must vanish
        out_ready = 1'b0;
        send(3'd5, 32'hABCD_E037, 32'h0000_2000);
        send(3'd2, 32'h0000_0863, 32'h0000_2004);
        do_flush();
        idle(1);
        out_ready = 1'b1;
        send(3'd6, 32'h0005_0073, 32'h0000_2008);
        idle(3);

        // Reset while full, then a NONE entry
        out_ready = 1'b0;
        send(3'd1, 32'h0010_0093, 32'h0000_3000);
        send(3'd3, 32'h0040_006F, 32'h0000_3004);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        out_ready = 1'b1;
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_3008);
        send(3'd7, 32'h0200_0013, 32'h0000_300C);
        idle(3);

        // Random traffic with random backpressure and occasional flushes
        rdy_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) do_flush();
            else if ($urandom_range(0, 3) == 0) idle(1);
            else send(3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        rdy_mode  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && q32.size() > 0; n++) idle(1);
        idle(1);
        chk("drain_empty", 64'(q32.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
